// File: rtl/io_responder.sv
// Memory-mapped I/O responder: four output registers, four synchronized inputs,
// an input FIFO with status/interrupt. Define IO_RESPONDER_SYNC_EN for a two-flop input synchronizer.
module io_responder #(
    parameter logic [15:0] BASE  = 16'hFF00,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addresses,
    input  logic        oe,
    input  logic        rd,
    inout  wire  [15:0] data_inout,
    input  logic [63:0] in_port,
    output logic [63:0] out_port,
    input  logic        fifo_wr,
    input  logic [15:0] fifo_din,
    output logic        irq
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [3:0][15:0] out_q, out_d;
    logic [3:0][15:0] in_q;
    logic [1:0]       ie_q, ie_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [15:0]      mem_q [DEPTH];

    logic        sel, wr_en, rd_en, full, empty, pop, push;
    logic [3:0]  off;
    logic [15:0] head, status, rdata;

    assign sel    = (addresses[15:4] == BASE[15:4]);
    assign off    = addresses[3:0];
    assign wr_en  = sel & oe;
    assign rd_en  = sel & rd & ~oe;
    assign full   = (cnt_q == 5'(DEPTH));
    assign empty  = (cnt_q == '0);
    assign pop    = rd_en & (off == 4'h8) & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push   = fifo_wr & (~full | pop);
    assign head   = empty ? '0 : mem_q[rp_q];
    assign status = {8'b0, cnt_q, ovf_q, full, empty};

    always_comb begin
        out_d = out_q;
        ie_d  = ie_q;
        ovf_d = ovf_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (wr_en) begin
            case (off)
                4'h0, 4'h1, 4'h2, 4'h3: out_d[off[1:0]] = data_inout;
                4'h9:                   if (data_inout[2]) ovf_d = 1'b0;
                4'hA:                   ie_d = data_inout[1:0];
                default:                ;
            endcase
        end
        if (fifo_wr & full & ~pop) ovf_d = 1'b1;
        if (push) wp_d = wp_q + 1'b1;
        if (pop)  rp_d = rp_q + 1'b1;
        cnt_d = cnt_q + {4'b0, push} - {4'b0, pop};
    end

    always_comb begin
        case (off)
            4'h0, 4'h1, 4'h2, 4'h3: rdata = out_q[off[1:0]];
            4'h4, 4'h5, 4'h6, 4'h7: rdata = in_q[off[1:0]];
            4'h8:                   rdata = head;
            4'h9:                   rdata = status;
            4'hA:                   rdata = {14'b0, ie_q};
            default:                rdata = '0;
        endcase
    end

    assign data_inout = rd_en ? rdata : 'z;
    assign out_port   = out_q;
    assign irq        = (ie_q[0] & ~empty) | (ie_q[1] & ovf_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            ie_q  <= '0;
            ovf_q <= 1'b0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            ie_q  <= ie_d;
            ovf_q <= ovf_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= fifo_din;
    end

`ifdef IO_RESPONDER_SYNC_EN
    logic [63:0] meta_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            in_q   <= '0;
        end else begin
            meta_q <= in_port;
            in_q   <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_q <= '0;
        else        in_q <= in_port;
    end
`endif

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: register map, FIFO corner cases, irq, reset, input latency.
module tb_io_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addresses = '0;
    logic        oe = 1'b0;
    logic        rd = 1'b0;
    logic [63:0] in_port = '0;
    logic [63:0] out_port;
    logic        fifo_wr = 1'b0;
    logic [15:0] fifo_din = '0;
    logic        irq;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;
    wire  [15:0] data_inout;

    int n_checks = 0;
    int n_fail   = 0;

    assign data_inout = drv_en ? drv : 'z;

    io_responder #(.BASE(16'hFF00), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .addresses(addresses), .oe(oe), .rd(rd),
        .data_inout(data_inout), .in_port(in_port), .out_port(out_port),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .irq(irq)
    );

    always #5 clk = ~clk;

`ifdef IO_RESPONDER_SYNC_EN
    localparam int IN_LAT = 2;
`else
    localparam int IN_LAT = 1;
`endif

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        addresses = a; oe = 1'b1; rd = 1'b0; drv = d; drv_en = 1'b1;
        @(posedge clk); #1;
        oe = 1'b0; drv_en = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        @(negedge clk);
        addresses = a; rd = 1'b1; oe = 1'b0;
        #1 check_eq(tag, 64'(data_inout), 64'(exp));
        @(posedge clk); #1;
        rd = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk);
        fifo_wr = 1'b1; fifo_din = d;
        @(posedge clk); #1;
        fifo_wr = 1'b0;
    endtask

    // Pop and push in the same cycle.
    task automatic pop_push(input string tag, input logic [15:0] d, input logic [15:0] exp);
        @(negedge clk);
        addresses = 16'hFF08; rd = 1'b1; oe = 1'b0; fifo_wr = 1'b1; fifo_din = d;
        #1 check_eq(tag, 64'(data_inout), 64'(exp));
        @(posedge clk); #1;
        rd = 1'b0; fifo_wr = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2 check_eq("rst_out_port", out_port, 64'h0);
        check_eq("rst_irq", 64'(irq), 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        bus_rd("status_after_reset", 16'hFF09, 16'h0001);

        bus_wr(16'hFF01, 16'hA5A5);
        check_eq("out1_written", out_port, 64'h0000_0000_A5A5_0000);
        bus_rd("read_out1", 16'hFF01, 16'hA5A5);
        bus_wr(16'hFF10, 16'h1111);
        check_eq("unselected_write", out_port, 64'h0000_0000_A5A5_0000);
        bus_wr(16'hFF0B, 16'h2222);
        bus_rd("unmapped_read", 16'hFF0B, 16'h0000);
        bus_wr(16'hFF03, 16'hC3C3);
        check_eq("out3_written", out_port, 64'hC3C3_0000_A5A5_0000);

        for (int i = 1; i <= 4; i++) push(16'(i));
        bus_rd("status_full", 16'hFF09, 16'h0022);
        push(16'h0005);
        bus_rd("status_ovf", 16'hFF09, 16'h0026);
        for (int i = 1; i <= 4; i++) bus_rd("pop_order", 16'hFF08, 16'(i));
        bus_rd("status_drained", 16'hFF09, 16'h0005);
        bus_rd("pop_empty", 16'hFF08, 16'h0000);
        bus_wr(16'hFF09, 16'h0004);
        bus_rd("status_ovf_cleared", 16'hFF09, 16'h0001);

        bus_wr(16'hFF0A, 16'h0001);
        check_eq("irq_ie1_empty", 64'(irq), 64'h0);
        push(16'h0007);
        check_eq("irq_nonempty", 64'(irq), 64'h1);
        bus_rd("pop_irq_word", 16'hFF08, 16'h0007);
        check_eq("irq_after_pop", 64'(irq), 64'h0);
        for (int i = 0; i < 4; i++) push(16'h0010 + 16'(i));
        push(16'h00EE);
        bus_wr(16'hFF0A, 16'h0002);
        check_eq("irq_ovf", 64'(irq), 64'h1);
        bus_wr(16'hFF09, 16'h0004);
        check_eq("irq_ovf_cleared", 64'(irq), 64'h0);
        bus_rd("read_ie", 16'hFF0A, 16'h0002);

        pop_push("full_pop_push", 16'h0014, 16'h0010);
        bus_rd("status_full_no_ovf", 16'hFF09, 16'h0022);
        for (int i = 1; i <= 4; i++) bus_rd("pop_after_swap", 16'hFF08, 16'h0010 + 16'(i));

        pop_push("empty_pop_push", 16'h0055, 16'h0000);
        bus_rd("status_count1", 16'hFF09, 16'h0008);
        bus_rd("pop_55", 16'hFF08, 16'h0055);

        push(16'h0066);
        @(negedge clk);
        addresses = 16'hFF08; oe = 1'b1; rd = 1'b1; drv = 16'h0000; drv_en = 1'b1;
        @(posedge clk); #1;
        addresses = 16'hFF00; drv = 16'hBEEF;
        @(posedge clk); #1;
        oe = 1'b0; rd = 1'b0; drv_en = 1'b0;
        check_eq("oe_rd_write", out_port, 64'hC3C3_0000_A5A5_BEEF);
        bus_rd("oe_rd_no_pop", 16'hFF09, 16'h0008);
        bus_rd("pop_66", 16'hFF08, 16'h0066);

        bus_wr(16'hFF0A, 16'h0001);
        push(16'h0077);
        push(16'h0078);
        check_eq("irq_before_reset", 64'(irq), 64'h1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_eq("midop_reset_out", out_port, 64'h0);
        check_eq("midop_reset_irq", 64'(irq), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        bus_rd("status_after_midop", 16'hFF09, 16'h0001);
        bus_rd("pop_after_midop", 16'hFF08, 16'h0000);

        @(negedge clk);
        in_port[47:32] = 16'h1234;
        addresses = 16'hFF06; rd = 1'b1; oe = 1'b0;
        #1 check_eq("in2_edge0", 64'(data_inout), 64'h0);
        @(negedge clk);
        check_eq("in2_edge1", 64'(data_inout), (IN_LAT == 1) ? 64'h1234 : 64'h0);
        @(negedge clk);
        check_eq("in2_edge2", 64'(data_inout), 64'h1234);
        rd = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter BASE, 16'hFF00, I/O window base; block selected when addresses[15:4] == BASE[15:4].
REQ-002 Parameter DEPTH, 4, input FIFO depth (power of two, 2..16).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 addresses  input  16  CPU bus address (CPU ALU result).
REQ-006 oe  input  1  CPU drives data_inout this cycle (store/write).
REQ-007 rd  input  1  CPU samples data_inout this cycle (load/read).
REQ-008 data_inout  inout  16  shared bidirectional data bus.
REQ-009 in_port  input  64  four 16-bit external input ports IN0..IN3 (IN0 = [15:0]).
REQ-010 out_port  output  64  four 16-bit output port registers OUT0..OUT3 (OUT0 = [15:0]).
REQ-011 fifo_wr  input  1  external producer push strobe.
REQ-012 fifo_din  input  16  external producer push data.
REQ-013 irq  output  1  level interrupt request to CPU interrupt line.

Function
REQ-014 Offset map (addresses[3:0]): 0x0-0x3 OUTn R/W; 0x4-0x7 INn read-only; 0x8 FIFO pop (read); 0x9 STATUS; 0xA IE (R/W, bits[1:0]); others read 16'h0000, writes ignored.
REQ-015 STATUS = {8'b0, count[4:0], ovf, full, empty} at bits [15:0]; write to 0x9 with data bit[2]=1 clears ovf.
REQ-016 Write: selected & oe -> target register loads data_inout at that rising edge; visible next cycle.
REQ-017 Read: selected & rd & ~oe -> data_inout driven combinationally in the same cycle with current register value; otherwise data_inout = high-Z.
REQ-018 oe & rd together: write only, no drive, no pop.
REQ-019 FIFO pop: read of 0x8 returns head word same cycle; head removed at end-of-cycle edge; pop when empty returns 16'h0000, no state change.
REQ-020 FIFO push: fifo_wr stores fifo_din at tail on edge; pointers wrap modulo DEPTH.
REQ-021 Push while full without simultaneous pop: data dropped, ovf set (sticky), count unchanged.
REQ-022 Push and pop same cycle: count unchanged; when full, accepted without ovf; when empty, pop returns 0 and push accepted (count becomes 1).
REQ-023 full = (count == DEPTH); empty = (count == 0); count width 5 bits.
REQ-024 irq = (IE[0] & ~empty) | (IE[1] & ovf), combinational from registered state.
REQ-025 INn read value is the synchronized sample (REQ-030), never raw in_port.

Reset
REQ-026 reset low asynchronously clears OUT0..3, IE, ovf, FIFO pointers and count, synchronizer flops.
REQ-027 During reset: out_port = 0, irq = 0, data_inout high-Z, STATUS reads 16'h0001 after release.
REQ-028 Reset mid-operation discards FIFO contents; first pop after release returns 0.
REQ-029 FIFO storage array is not reset; only pointers/count.

Configuration
REQ-030 Macro IO_RESPONDER_SYNC_EN: defined -> in_port passes through two-flop synchronizer (INn read reflects in_port 2 edges later); undefined -> single register stage (1 edge latency).

Verification
REQ-031 After reset: read 0x9 -> 16'h0001; out_port = 0; irq = 0; data_inout = Z when rd low.
REQ-032 Write 16'hA5A5 to BASE+1 -> OUT1 = A5A5 next cycle; read BASE+1 returns A5A5; address BASE+0x10 write leaves all OUTn unchanged.
REQ-033 Push 1,2,3,4 (DEPTH=4) -> STATUS full=1, count=4; 5th push -> ovf=1, data 5 lost; pops return 1,2,3,4 then 0; write 16'h0004 to 0x9 clears ovf.
REQ-034 IE=1, push one word -> irq=1 next cycle; pop it -> irq=0 next cycle; IE=2 with ovf set -> irq=1.
REQ-035 FIFO full, fifo_wr and pop of 0x8 same cycle -> pop returns oldest, new word stored, ovf stays 0, count stays 4.
REQ-036 in_port IN2 changes to 16'h1234 -> read 0x6 shows 1234 after 2 edges with IO_RESPONDER_SYNC_EN, after 1 edge without.
